// File: rtl/ascii_frame_loader_if.sv
// Bundle of the loader's byte stream, register-file write port, converter
// handshake and result signals. The loader takes the slave view.
interface ascii_frame_loader_if;
   // upstream byte stream
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic       in_ready;

   // shared register-file write port
   logic       W_en;
   logic [3:0] W_Addr;
   logic [7:0] W_Data;

   // converter handshake
   logic       go;
   logic       conv_done;
   logic [4:0] conv_count;

   // status and result
   logic       busy;
   logic       result_valid;
   logic [4:0] result_count;
   logic       overflow;
   logic       timeout;

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
      output in_ready,
      output W_en,
      output W_Addr,
      output W_Data,
      output go,
      input  conv_done,
      input  conv_count,
      output busy,
      output result_valid,
      output result_count,
      output overflow,
      output timeout
   );

   modport master (
      output in_valid,
      output in_data,
      output in_last,
      input  in_ready,
      input  W_en,
      input  W_Addr,
      input  W_Data,
      input  go,
      output conv_done,
      output conv_count,
      input  busy,
      input  result_valid,
      input  result_count,
      input  overflow,
      input  timeout
   );
endinterface

// File: rtl/ascii_frame_loader.sv
// Loads one byte frame into register-file entries 0..15, pads the remainder,
// starts the ASCII-digit converter and reports its digit count.
module ascii_frame_loader #(
   parameter logic [7:0] PAD_CHAR = 8'h20,
   parameter int         WAIT_MAX = 255
) (
   input logic                 Clk,
   input logic                 Rst,
   ascii_frame_loader_if.slave bus
);

   localparam logic [2:0] S_LOAD   = 3'd0;
   localparam logic [2:0] S_DRAIN  = 3'd1;
   localparam logic [2:0] S_FILL   = 3'd2;
   localparam logic [2:0] S_START  = 3'd3;
   localparam logic [2:0] S_WAIT   = 3'd4;
   localparam logic [2:0] S_REPORT = 3'd5;

   localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

   logic [2:0] state_reg, state_next;
   logic [3:0] ptr_reg, ptr_next;
   logic [7:0] wcnt_reg, wcnt_next;
   logic [4:0] result_count_reg, result_count_next;
   logic       overflow_reg, overflow_next;
   logic       timeout_reg, timeout_next;

   logic       in_ready;
   logic       accept;
   logic       w_en;
   logic [3:0] w_addr;
   logic [7:0] w_data;

   // Gating with Rst keeps the write port and handshake quiet while reset is held.
   assign in_ready = Rst && ((state_reg == S_LOAD) || (state_reg == S_DRAIN));
   assign accept   = in_ready && bus.in_valid;

   always_comb begin
      state_next        = state_reg;
      ptr_next          = ptr_reg;
      wcnt_next         = wcnt_reg;
      result_count_next = result_count_reg;
      overflow_next     = overflow_reg;
      timeout_next      = timeout_reg;
      w_en              = 1'b0;
      w_addr            = 4'd0;
      w_data            = 8'd0;

      case (state_reg)
         S_LOAD: begin
            if (accept) begin
               w_en   = 1'b1;
               w_addr = ptr_reg;
               w_data = bus.in_data;
               if (ptr_reg == 4'd0) begin
                  overflow_next = 1'b0;
                  timeout_next  = 1'b0;
               end
               if (ptr_reg == 4'd15) begin
                  if (bus.in_last) begin
                     state_next = S_START;
                  end else begin
                     state_next    = S_DRAIN;
                     overflow_next = 1'b1;
                  end
               end else begin
                  ptr_next = ptr_reg + 4'd1;
                  if (bus.in_last) begin
                     state_next = S_FILL;
                  end
               end
            end
         end

         S_DRAIN: begin
            if (accept && bus.in_last) begin
               state_next = S_START;
            end
         end

         S_FILL: begin
            w_en   = 1'b1;
            w_addr = ptr_reg;
            w_data = PAD_CHAR;
            if (ptr_reg == 4'd15) begin
               state_next = S_START;
            end else begin
               ptr_next = ptr_reg + 4'd1;
            end
         end

         S_START: begin
            ptr_next   = 4'd0;
            wcnt_next  = 8'd0;
            state_next = S_WAIT;
         end

         // conv_done wins over an expiring wait counter
         S_WAIT: begin
            if (bus.conv_done) begin
               result_count_next = bus.conv_count;
               state_next        = S_REPORT;
            end else if (wcnt_reg == WAIT_LAST) begin
               timeout_next      = 1'b1;
               result_count_next = 5'd0;
               state_next        = S_REPORT;
            end else begin
               wcnt_next = wcnt_reg + 8'd1;
            end
         end

         S_REPORT: begin
            state_next = S_LOAD;
         end

         default: begin
            state_next = S_LOAD;
            ptr_next   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_reg        <= S_LOAD;
         ptr_reg          <= 4'd0;
         wcnt_reg         <= 8'd0;
         result_count_reg <= 5'd0;
         overflow_reg     <= 1'b0;
         timeout_reg      <= 1'b0;
      end else begin
         state_reg        <= state_next;
         ptr_reg          <= ptr_next;
         wcnt_reg         <= wcnt_next;
         result_count_reg <= result_count_next;
         overflow_reg     <= overflow_next;
         timeout_reg      <= timeout_next;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.W_en         = w_en;
   assign bus.W_Addr       = w_addr;
   assign bus.W_Data       = w_data;
   assign bus.go           = (state_reg == S_START);
   assign bus.result_valid = (state_reg == S_REPORT);
   assign bus.busy         = !((state_reg == S_LOAD) && (ptr_reg == 4'd0));
   assign bus.result_count = result_count_reg;
   assign bus.overflow     = overflow_reg;
   assign bus.timeout      = timeout_reg;

endmodule

// File: doc/ascii_frame_loader.md
Name: ascii_frame_loader

Overview:
- Upstream stage of the ASCII-digit converter (HLSM); feeds it through the shared RegFile16x8.
- Accepts a byte stream with a valid/ready handshake and writes it into register-file entries 0..15.
- Pads unused entries with a non-digit byte, pulses go to the converter, waits for done, then reports the converter's digit count.

Parameters:
- PAD_CHAR, 8'h20, byte written to entries not covered by the frame; must be outside 8'h30..8'h39.
- WAIT_MAX, 255, cycles to wait for conv_done after go before declaring a timeout; range 1..255.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream byte valid.
- in_data  input  8  upstream ASCII byte.
- in_last  input  1  marks the final byte of a frame; qualified by in_valid.
- in_ready  output  1  loader can accept a byte this cycle.
- W_en  output  1  register-file write enable.
- W_Addr  output  4  register-file write address.
- W_Data  output  8  register-file write data.
- go  output  1  one-cycle start pulse to the converter.
- conv_done  input  1  converter done; one-cycle pulse.
- conv_count  input  5  converter digit count; valid while conv_done=1.
- busy  output  1  frame in progress (any state other than LOAD with ptr=0).
- result_valid  output  1  one-cycle pulse; result_count, overflow and timeout are valid.
- result_count  output  5  latched conv_count (0..16).
- overflow  output  1  frame exceeded 16 bytes; extra bytes were discarded.
- timeout  output  1  conv_done did not arrive within WAIT_MAX cycles.

Behaviour:
- Internal state: 4-bit write pointer ptr, 8-bit wait counter wcnt, and state register with states LOAD, DRAIN, FILL, START, WAIT, REPORT.
- Reset (Rst=0, asynchronous): state=LOAD, ptr=0, wcnt=0, result_count=0. overflow, timeout, result_valid, go and W_en all 0.
- Reset mid-frame abandons the frame. Entries already written are not cleared.
- W_en/W_Addr/W_Data are combinational from state, ptr and the handshake. Writes commit at the next rising edge. W_Addr=0 and W_Data=0 when W_en=0.
- LOAD:
  - in_ready=1.
  - On in_valid: W_en=1, W_Addr=ptr, W_Data=in_data.
  - If ptr=15 and in_last=0: go to DRAIN and set overflow.
  - If ptr=15 and in_last=1: go to START.
  - Else if in_last=1: ptr<=ptr+1, go to FILL.
  - Else: ptr<=ptr+1.
  - The first accepted byte clears overflow and timeout.
- DRAIN:
  - in_ready=1; accepted bytes are discarded (W_en=0).
  - Accepted byte with in_last=1 -> START.
- FILL:
  - in_ready=0; W_en=1, W_Addr=ptr, W_Data=PAD_CHAR.
  - ptr=15 -> START; else ptr<=ptr+1.
  - A frame of N bytes (N<16) therefore takes 16-N FILL cycles.
- START: go=1 for exactly one cycle, ptr<=0, wcnt<=0, then WAIT. in_ready=0.
- WAIT:
  - in_ready=0.
  - If conv_done=1: result_count<=conv_count, go to REPORT.
  - Else if wcnt=WAIT_MAX-1: timeout<=1, result_count<=0, go to REPORT.
  - Else wcnt<=wcnt+1.
  - conv_done takes priority if it arrives in the same cycle the timeout would expire.
- REPORT: result_valid=1 for one cycle, then LOAD with ptr=0. in_ready=0.
- A conv_done arriving in any state other than WAIT is ignored.
- overflow, timeout and result_count hold until the next frame's first byte or reset.
- Empty frames cannot occur: in_last always accompanies a byte.
- Throughput: one byte per cycle while in_valid=1 in LOAD/DRAIN.

Test Plan:
- Reset: assert Rst=0 mid-LOAD after 5 bytes -> all outputs 0 immediately; after release in_ready=1, busy=0, and the next byte is written at W_Addr=0.
- Short frame: send "7a3" (8'h37,8'h61,8'h33; last on 8'h33) -> writes to addresses 0..2, then PAD_CHAR to 3..15 over 13 cycles, one go pulse; converter returns conv_count=2 -> result_valid pulse, result_count=2, overflow=0.
- Exact 16 bytes: "0123456789ABCDEF" with last on byte 16 -> no FILL cycles, go on the next cycle; conv_count=10 -> result_count=10.
- Overflow: 20 digit bytes, last on byte 20 -> only the first 16 written, bytes 17..20 accepted with W_en=0, overflow=1; conv_count=16 -> result_count=16.
- Timeout: with WAIT_MAX=4, hold conv_done=0 -> exactly 4 WAIT cycles, then result_valid with timeout=1, result_count=0; a later stray conv_done is ignored.
- Back-to-back frames with in_valid held high: the second frame's bytes are stalled (in_ready=0) from START through REPORT, and its first byte clears the previous flags.
